crc_attach_ctrl: RTL

//  Sequencer for the serial CRC16 engine in the PUSCH transport-block chain.

---
 rtl/crc_attach_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/crc_attach_ctrl.sv
// Sequencer around a serial CRC16 engine: clears the engine, streams one transport
// block through it, then appends the engine's 16-bit result to the output stream.
module crc_attach_ctrl #(
    parameter int LEN_W         = 16,
    parameter int DRAIN_TIMEOUT = 31
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] tb_len_i,
    input  logic             in_bit_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             out_bit_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             crc_rst_n_o,
    output logic             crc_active_o,
    output logic             crc_data_in_o,
    input  logic [15:0]      crc_word_i,
    input  logic             crc_valid_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLR     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_APPEND  = 3'd4;
    localparam logic [2:0] S_ABORT   = 3'd5;

    localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 2);

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [15:0]       word_q, word_d;
    logic [3:0]        idx_q, idx_d;
    logic              out_bit_q, out_bit_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        word_d      = word_q;
        idx_d       = idx_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        err_d       = 1'b0;
        // done trails the last CRC bit by exactly one cycle
        done_d      = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (tb_len_i != '0) begin
                        len_d   = tb_len_i;
                        cnt_d   = '0;
                        state_d = S_CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLR: state_d = S_PAYLOAD;
            S_PAYLOAD: begin
                if (in_valid_i) begin
                    out_bit_d   = in_bit_i;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        dcnt_d  = '0;
                        state_d = S_DRAIN;
                    end
                end else begin
                    // the engine cannot tolerate a hole in its ACTIVE burst
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end
            end
            S_DRAIN: begin
                if (crc_valid_i) begin
                    word_d  = crc_word_i;
                    idx_d   = '0;
                    state_d = S_APPEND;
                end else if (dcnt_q == DCNT_W'(DRAIN_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_APPEND: begin
                out_bit_d   = word_q[idx_q];
                out_valid_d = 1'b1;
                idx_d       = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    out_last_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o    = (state_q == S_PAYLOAD);
    assign busy_o        = (state_q != S_IDLE);
    assign crc_active_o  = in_ready_o & in_valid_i;
    assign crc_data_in_o = in_ready_o & in_bit_i;
    assign crc_rst_n_o   = !(rst_i || state_q == S_CLR || state_q == S_ABORT);
    assign out_bit_o     = out_bit_q;
    assign out_valid_o   = out_valid_q;
    assign out_last_o    = out_last_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule
